// File: rtl/inst_dec.sv
// inst_dec: RV32I instruction field decoder with a valid/ready handshake.
// One registered stage: fields are decoded from the accepted word and held
// until the consumer takes them. Two saturating counters track accepted and
// illegal instructions.
// Optional feature macro: INST_DEC_SEXT_EN. When defined, imm32 carries the
// sign-extended byte offset for the decoded class. When undefined, imm32 is 0
// and no extension logic is built.
module inst_dec #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       inst_sel,
  output logic             illegal,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       func3,
  output logic [11:0]      immi,
  output logic [11:0]      imms,
  output logic [11:0]      immb,
  output logic [19:0]      immu,
  output logic [19:0]      immuj,
  output logic [31:0]      imm32,
  output logic [CNT_W-1:0] dec_cnt,
  output logic [CNT_W-1:0] ill_cnt
);

  // Class codes as seen by the generator and the datapath.
  typedef enum logic [3:0] {
    CLS_ILL = 4'd0,
    CLS_R0  = 4'd1,
    CLS_R1  = 4'd2,
    CLS_I   = 4'd3,
    CLS_L   = 4'd4,
    CLS_S   = 4'd5,
    CLS_B   = 4'd6,
    CLS_U   = 4'd7,
    CLS_UJ  = 4'd8
  } cls_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_U  = 7'b0110111;
  localparam logic [6:0] OP_UJ = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef INST_DEC_SEXT_EN
  function automatic logic signed [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic signed [31:0] sext13(input logic [12:0] v);
    return {{19{v[12]}}, v};
  endfunction

  function automatic logic signed [31:0] sext21(input logic [20:0] v);
    return {{11{v[20]}}, v};
  endfunction
`endif

  logic accept;
  logic xfer;

  // ---- stage p0: combinational decode of the presented word ----
  cls_t        sel_p0;
  logic        ill_p0;
  logic [4:0]  rs1_p0;
  logic [4:0]  rs2_p0;
  logic [4:0]  rd_p0;
  logic [2:0]  func3_p0;
  logic [11:0] immi_p0;
  logic [11:0] imms_p0;
  logic [11:0] immb_p0;
  logic [19:0] immu_p0;
  logic [19:0] immuj_p0;

  // Register and immediate fields are extracted raw for every class; the
  // consumer decides which ones matter by looking at inst_sel.
  assign rs1_p0   = inst[19:15];
  assign rs2_p0   = inst[24:20];
  assign rd_p0    = inst[11:7];
  assign func3_p0 = inst[14:12];
  assign immi_p0  = inst[31:20];
  assign imms_p0  = {inst[31:25], inst[11:7]};
  assign immb_p0  = {inst[31], inst[7], inst[30:25], inst[11:8]};
  assign immu_p0  = inst[31:12];
  assign immuj_p0 = {inst[31], inst[19:12], inst[20], inst[30:21]};

  // Opcode and func7 to class code; anything unrecognised is illegal.
  always_comb begin
    sel_p0 = CLS_ILL;
    unique case (inst[6:0])
      OP_R: begin
        if (inst[31:25] == F7_BASE)     sel_p0 = CLS_R0;
        else if (inst[31:25] == F7_ALT) sel_p0 = CLS_R1;
        else                            sel_p0 = CLS_ILL;
      end
      OP_I:    sel_p0 = CLS_I;
      OP_L:    sel_p0 = CLS_L;
      OP_S:    sel_p0 = CLS_S;
      OP_B:    sel_p0 = CLS_B;
      OP_U:    sel_p0 = CLS_U;
      OP_UJ:   sel_p0 = CLS_UJ;
      default: sel_p0 = CLS_ILL;
    endcase
  end

  assign ill_p0 = (sel_p0 == CLS_ILL);

`ifdef INST_DEC_SEXT_EN
  logic [31:0] imm32_p0;

  // Byte-offset immediate chosen by class; B and UJ store imm[n:1] so the
  // implicit zero LSB is restored before extension.
  always_comb begin
    imm32_p0 = '0;
    case (sel_p0)
      CLS_I, CLS_L: imm32_p0 = sext12(immi_p0);
      CLS_S:        imm32_p0 = sext12(imms_p0);
      CLS_B:        imm32_p0 = sext13({immb_p0, 1'b0});
      CLS_U:        imm32_p0 = {immu_p0, 12'h000};
      CLS_UJ:       imm32_p0 = sext21({immuj_p0, 1'b0});
      default:      imm32_p0 = '0;
    endcase
  end
`endif

  // The only input-to-output path: ready whenever the output slot is empty
  // or being drained this cycle.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  // ---- stage p1: registered decode results ----
  logic        vld_p1;
  logic [3:0]  sel_p1;
  logic        ill_p1;
  logic [4:0]  rs1_p1;
  logic [4:0]  rs2_p1;
  logic [4:0]  rd_p1;
  logic [2:0]  func3_p1;
  logic [11:0] immi_p1;
  logic [11:0] imms_p1;
  logic [11:0] immb_p1;
  logic [19:0] immu_p1;
  logic [19:0] immuj_p1;

  // Load a new result on accept, otherwise drop valid once it is taken;
  // while stalled nothing changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      sel_p1   <= CLS_ILL;
      ill_p1   <= 1'b0;
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      rd_p1    <= '0;
      func3_p1 <= '0;
      immi_p1  <= '0;
      imms_p1  <= '0;
      immb_p1  <= '0;
      immu_p1  <= '0;
      immuj_p1 <= '0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      sel_p1   <= sel_p0;
      ill_p1   <= ill_p0;
      rs1_p1   <= rs1_p0;
      rs2_p1   <= rs2_p0;
      rd_p1    <= rd_p0;
      func3_p1 <= func3_p0;
      immi_p1  <= immi_p0;
      imms_p1  <= imms_p0;
      immb_p1  <= immb_p0;
      immu_p1  <= immu_p0;
      immuj_p1 <= immuj_p0;
    end else if (xfer) begin
      vld_p1   <= 1'b0;
    end
  end

`ifdef INST_DEC_SEXT_EN
  logic [31:0] imm32_p1;

  // Extended immediate follows the same load/hold rule as the other fields.
  always_ff @(posedge clk) begin
    if (rst)         imm32_p1 <= '0;
    else if (accept) imm32_p1 <= imm32_p0;
  end

  assign imm32 = imm32_p1;
`else
  assign imm32 = '0;
`endif

  logic [CNT_W-1:0] dec_cnt_p1;
  logic [CNT_W-1:0] ill_cnt_p1;

  // Count accepted words and accepted illegal words, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt_p1 <= '0;
      ill_cnt_p1 <= '0;
    end else if (accept) begin
      dec_cnt_p1 <= sat_inc(dec_cnt_p1);
      if (ill_p0) ill_cnt_p1 <= sat_inc(ill_cnt_p1);
    end
  end

  assign out_valid = vld_p1;
  assign inst_sel  = sel_p1;
  assign illegal   = ill_p1;
  assign rs1       = rs1_p1;
  assign rs2       = rs2_p1;
  assign rd        = rd_p1;
  assign func3     = func3_p1;
  assign immi      = immi_p1;
  assign imms      = imms_p1;
  assign immb      = immb_p1;
  assign immu      = immu_p1;
  assign immuj     = immuj_p1;
  assign dec_cnt   = dec_cnt_p1;
  assign ill_cnt   = ill_cnt_p1;

endmodule

// File: tb/tb_inst_dec.sv
// Testbench for inst_dec: directed cases plus randomized traffic with random
// backpressure, checked against a scoreboard fed by a field-level model and
// an instruction generator. Counters use a narrow width so saturation occurs.
module tb_inst_dec;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   inst;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    inst_sel;
  logic          illegal;
  logic [4:0]    rs1, rs2, rd;
  logic [2:0]    func3;
  logic [11:0]   immi, imms, immb;
  logic [19:0]   immu, immuj;
  logic [31:0]   imm32;
  logic [CW-1:0] dec_cnt, ill_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  inst_dec #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .out_valid(out_valid), .out_ready(out_ready),
    .inst_sel(inst_sel), .illegal(illegal), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func3(func3), .immi(immi), .imms(imms), .immb(immb), .immu(immu),
    .immuj(immuj), .imm32(imm32), .dec_cnt(dec_cnt), .ill_cnt(ill_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    int sel, ill, rs1, rs2, rd, f3, immi, imms, immb, immu, immuj, imm32;
    int gsel, g_rs1, g_rs2, g_rd, g_f3, g_imm;
  } exp_t;

  int   opmap[int];
  exp_t q[$];
  exp_t cur;
  bit   mv;
  int   dec_m, ill_m, n_xfer;

  function automatic int fld(input logic [31:0] w, input int lo, input int n);
    return int'((w >> lo) & ((32'd1 << n) - 32'd1));
  endfunction

  function automatic int sx(input int v, input int n);
    return (v >= (1 << (n - 1))) ? v - (1 << n) : v;
  endfunction

  // Spec-level model: every field is a positional bit extraction of the word.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int op, f7;
    op = fld(w, 0, 7);
    f7 = fld(w, 25, 7);
    e = '{default: 0};
    if (op == 'h33)            e.sel = (f7 == 0) ? 1 : (f7 == 'h20) ? 2 : 0;
    else if (opmap.exists(op)) e.sel = opmap[op];
    e.ill   = (e.sel == 0) ? 1 : 0;
    e.rs1   = fld(w, 15, 5);
    e.rs2   = fld(w, 20, 5);
    e.rd    = fld(w, 7, 5);
    e.f3    = fld(w, 12, 3);
    e.immi  = fld(w, 20, 12);
    e.imms  = fld(w, 25, 7) * 32 + fld(w, 7, 5);
    e.immb  = fld(w, 31, 1) * 2048 + fld(w, 7, 1) * 1024 + fld(w, 25, 6) * 16 + fld(w, 8, 4);
    e.immu  = fld(w, 12, 20);
    e.immuj = fld(w, 31, 1) * 524288 + fld(w, 12, 8) * 2048 + fld(w, 20, 1) * 1024 + fld(w, 21, 10);
`ifdef INST_DEC_SEXT_EN
    case (e.sel)
      3, 4:    e.imm32 = sx(e.immi, 12);
      5:       e.imm32 = sx(e.imms, 12);
      6:       e.imm32 = sx(e.immb * 2, 13);
      7:       e.imm32 = e.immu << 12;
      8:       e.imm32 = sx(e.immuj * 2, 21);
      default: e.imm32 = 0;
    endcase
`endif
    return e;
  endfunction

  // Instruction generator in standard RV32I layouts. imm is the 12-bit
  // immediate (I/L), the 20-bit upper immediate (U) or a signed even byte
  // offset (B/UJ).
  function automatic logic [31:0] gen(input int sel, input logic [4:0] r1, input logic [4:0] r2,
                                      input logic [4:0] d, input logic [2:0] f3, input int imm);
    logic [31:0] v;
    logic [31:0] w;
    v = imm;
    case (sel)
      3:       w = {v[11:0], r1, f3, d, 7'b0010011};
      4:       w = {v[11:0], r1, f3, d, 7'b0000011};
      6:       w = {v[12], v[10:5], r2, r1, f3, v[4:1], v[11], 7'b1100011};
      7:       w = {v[19:0], d, 7'b0110111};
      default: w = {v[20], v[10:1], v[11], v[19:12], d, 7'b1101111};
    endcase
    return w;
  endfunction

  task automatic present(input logic [31:0] w);
    inst = w;
    cur  = model(w);
  endtask

  task automatic present_gen();
    int sel, imm;
    logic [4:0] r1, r2, d;
    logic [2:0] f3;
    int pick[5] = '{3, 4, 6, 7, 8};
    sel = pick[$urandom_range(0, 4)];
    r1 = 5'($urandom); r2 = 5'($urandom); d = 5'($urandom); f3 = 3'($urandom);
    case (sel)
      3, 4:    imm = int'($urandom_range(0, 4095));
      6:       imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
      7:       imm = int'($urandom_range(0, (1 << 20) - 1));
      default: imm = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
    endcase
    present(gen(sel, r1, r2, d, f3, imm));
    cur.gsel = sel; cur.g_rs1 = r1; cur.g_rs2 = r2; cur.g_rd = d; cur.g_f3 = f3; cur.g_imm = imm;
  endtask

  task automatic present_rand();
    logic [31:0] w;
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 5) present_gen();
    else begin
      w = $urandom;
      if (k == 5) begin
        w[6:0] = 7'h33;
        w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end else if (k == 6) w[6:0] = 7'h33;
      else if (k == 7) w[6:0] = 7'h23;
      present(w);
    end
  endtask

  task automatic cmp_out(input exp_t e);
    chk("sel", inst_sel, e.sel);
    chk("illegal", illegal, e.ill);
    chk("rs1", rs1, e.rs1);
    chk("rs2", rs2, e.rs2);
    chk("rd", rd, e.rd);
    chk("func3", func3, e.f3);
    chk("immi", immi, e.immi);
    chk("imms", imms, e.imms);
    chk("immb", immb, e.immb);
    chk("immu", immu, e.immu);
    chk("immuj", immuj, e.immuj);
    chk("imm32", imm32, e.imm32);
    if (e.gsel != 0) begin
      chk("rt_sel", inst_sel, e.gsel);
      case (e.gsel)
        3, 4: begin
          chk("rt_rd", rd, e.g_rd); chk("rt_rs1", rs1, e.g_rs1);
          chk("rt_f3", func3, e.g_f3); chk("rt_immi", immi, e.g_imm);
        end
        6: begin
          chk("rt_rs1", rs1, e.g_rs1); chk("rt_rs2", rs2, e.g_rs2);
          chk("rt_f3", func3, e.g_f3); chk("rt_boff", sx(int'(immb) * 2, 13), e.g_imm);
        end
        7: begin
          chk("rt_rd", rd, e.g_rd); chk("rt_immu", immu, e.g_imm);
        end
        default: begin
          chk("rt_rd", rd, e.g_rd); chk("rt_joff", sx(int'(immuj) * 2, 21), e.g_imm);
        end
      endcase
    end
  endtask

  // One clock cycle of handshake, judged from the model's own view of the
  // output slot; called with inputs already driven.
  task automatic cyc(output bit acc);
    bit xf;
    #1;
    chk("in_ready", in_ready, !mv | out_ready);
    chk("out_valid", out_valid, mv);
    acc = in_valid & (!mv | out_ready);
    xf  = mv & out_ready;
    if (xf) begin
      n_xfer++;
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else cmp_out(q.pop_front());
    end
    if (acc) begin
      q.push_back(cur);
      if (dec_m < CMAX) dec_m++;
      if (cur.ill != 0 && ill_m < CMAX) ill_m++;
    end
    mv = acc ? 1'b1 : (xf ? 1'b0 : mv);
    @(posedge clk); #1;
    chk("dec_cnt", dec_cnt, dec_m);
    chk("ill_cnt", ill_cnt, ill_m);
  endtask

  task automatic clr_model();
    q.delete(); mv = 0; dec_m = 0; ill_m = 0; n_xfer = 0;
  endtask

  task automatic reset_dut();
    rst = 1; in_valid = 1; inst = $urandom; out_ready = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel", inst_sel, 0);
    chk("rst_dec_cnt", dec_cnt, 0);
    chk("rst_ill_cnt", ill_cnt, 0);
    rst = 0; in_valid = 0;
    clr_model();
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic send_one(input logic [31:0] w);
    bit acc;
    present(w); in_valid = 1; out_ready = 1;
    cyc(acc);
    in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc, have;
    int idx;
    logic [31:0] bwv[4];
    exp_t be[4];
    logic [21:0] snap_f;
    logic [11:0] snap_i;

    opmap['h13] = 3; opmap['h03] = 4; opmap['h23] = 5;
    opmap['h63] = 6; opmap['h37] = 7; opmap['h6F] = 8;
    rst = 1; in_valid = 0; inst = '0; out_ready = 1;
    clr_model();

    reset_dut();

    send_one(32'h00C58533);
    chk("r0_sel", inst_sel, 1); chk("r0_rd", rd, 10); chk("r0_rs1", rs1, 11);
    chk("r0_rs2", rs2, 12); chk("r0_f3", func3, 0);
    send_one(32'h40C58533);
    chk("r1_sel", inst_sel, 2);
    send_one(32'hFFF00293);
    chk("i_sel", inst_sel, 3); chk("i_immi", immi, 12'hFFF); chk("i_rd", rd, 5);
`ifdef INST_DEC_SEXT_EN
    chk("i_imm32", imm32, 32'hFFFFFFFF);
`else
    chk("i_imm32", imm32, 32'h0);
`endif
    send_one(32'h0020A023);
    chk("s_sel", inst_sel, 5); chk("s_rs1", rs1, 1); chk("s_rs2", rs2, 2);
    chk("s_f3", func3, 2); chk("s_imms", imms, 0);
    out_ready = 1; cyc(acc);

    reset_dut();
    send_one(32'h0000007F);
    send_one(32'h80C58533);
    chk("ill_sel", inst_sel, 0); chk("ill_flag", illegal, 1);
    chk("ill_cnt2", ill_cnt, 2); chk("ill_dec_cnt2", dec_cnt, 2);
    out_ready = 1; cyc(acc);

    // Four words with a three-cycle stall once the second is on the output.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      present_gen(); bwv[i] = inst; be[i] = cur;
    end
    idx = 0;
    for (int k = 0; k < 30 && n_xfer < 4; k++) begin
      if (idx < 4) begin inst = bwv[idx]; cur = be[idx]; in_valid = 1; end
      else in_valid = 0;
      out_ready = !(k >= 2 && k <= 4);
      if (k == 2) begin snap_f = {inst_sel, rd, rs1, rs2, func3}; snap_i = immi; end
      if (k >= 3 && k <= 5) begin
        chk("stall_hold_f", {10'd0, inst_sel, rd, rs1, rs2, func3}, {10'd0, snap_f});
        chk("stall_hold_i", immi, snap_i);
      end
      if (k >= 2 && k <= 4) begin #1; chk("stall_in_ready", in_ready, 0); end
      cyc(acc);
      if (acc) idx++;
    end
    in_valid = 0;
    chk("bp_xfers", n_xfer, 4);
    chk("bp_accepts", idx, 4);
    chk("bp_dec_cnt", dec_cnt, 4);

    // Reset while a result is stalled on the output.
    send_one(32'h00C58533);
    out_ready = 0; cyc(acc);
    rst = 1;
    @(posedge clk); #1;
    chk("stall_rst_out_valid", out_valid, 0);
    chk("stall_rst_dec_cnt", dec_cnt, 0);
    rst = 0;
    clr_model();

    // Randomized traffic with random backpressure; counters saturate here.
    reset_dut();
    have = 0;
    for (int k = 0; k < 600; k++) begin
      if (!have) begin present_rand(); have = 1; end
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      cyc(acc);
      if (acc || !in_valid) have = 0;
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) cyc(acc);
    chk("drain_empty", q.size(), 0);
    chk("sat_dec_cnt", dec_cnt, CMAX);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
